// File: rtl/qarith_pkg.sv
// Shared constants and types for the sign-magnitude Q-format adder.
package qarith_pkg;

    localparam int unsigned QARITH_Q    = 15;
    localparam int unsigned QARITH_N    = 32;
    localparam int unsigned QARITH_SIGN = QARITH_N - 1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage : qarith_pkg

// File: rtl/qadd_seq_if.sv
// Operand/result handshake bundle between a requester and the sequential adder.
interface qadd_seq_if
    import qarith_pkg::*;
#(
    parameter int unsigned N = QARITH_N
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, c, ovf
    );

endinterface : qadd_seq_if

// File: rtl/qmag_addsub.sv
// Combinational sign-magnitude add of two signed magnitudes with saturation.
module qmag_addsub
    import qarith_pkg::*;
#(
    parameter int unsigned N = QARITH_N
) (
    input  logic         sign_a,
    input  logic [N-2:0] mag_a,
    input  logic         sign_b,
    input  logic [N-2:0] mag_b,
    output logic         sign,
    output logic [N-2:0] mag,
    output logic         ovf
);

    localparam int unsigned MW = N - 1;

    logic          sa;
    logic          sb;
    logic [N-1:0]  sum;
    logic          a_ge_b;
    logic [MW-1:0] diff;

    always_comb begin
        sign   = 1'b0;
        mag    = '0;
        ovf    = 1'b0;
        // Negative zero collapses to +0 before sign comparison.
        sa     = sign_a & (|mag_a);
        sb     = sign_b & (|mag_b);
        sum    = {1'b0, mag_a} + {1'b0, mag_b};
        a_ge_b = (mag_a >= mag_b);
        diff   = a_ge_b ? (mag_a - mag_b) : (mag_b - mag_a);

        if (sa == sb) begin
            sign = sa;
            if (sum[N-1]) begin
                mag = '1;
                ovf = 1'b1;
            end else begin
                mag = sum[MW-1:0];
            end
        end else begin
            sign = a_ge_b ? sa : sb;
            mag  = diff;
        end

        if (mag == '0) begin
            sign = 1'b0;
        end
    end

endmodule : qmag_addsub

// File: rtl/qadd_seq.sv
// Sequential sign-magnitude adder/subtractor: accept, compute, hold until consumed.
module qadd_seq
    import qarith_pkg::*;
#(
    parameter int unsigned Q = QARITH_Q,
    parameter int unsigned N = QARITH_N
) (
    input  logic       clk,
    input  logic       rst,
    qadd_seq_if.slave  bus
);

    localparam int unsigned SB = N - 1;

    // Q is purely descriptive; only reject formats with no integer room.
    if (Q > N - 2) begin : g_q_range
        $error("qadd_seq: Q must leave at least one integer bit");
    end

    state_e       state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [N-1:0] c_q;
    logic         ovf_q;
    logic         a_sign_q;
    logic [N-2:0] a_mag_q;
    logic         b_sign_q;
    logic [N-2:0] b_mag_q;

    logic         res_sign_d;
    logic [N-2:0] res_mag_d;
    logic         res_ovf_d;

    qmag_addsub #(.N(N)) u_addsub (
        .sign_a (a_sign_q),
        .mag_a  (a_mag_q),
        .sign_b (b_sign_q),
        .mag_b  (b_mag_q),
        .sign   (res_sign_d),
        .mag    (res_mag_d),
        .ovf    (res_ovf_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            a_sign_q    <= 1'b0;
            a_mag_q     <= '0;
            b_sign_q    <= 1'b0;
            b_mag_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sign_q   <= bus.a[SB];
                        a_mag_q    <= bus.a[N-2:0];
                        // Subtraction is addition with b's sign flipped.
                        b_sign_q   <= bus.b[SB] ^ (bus.op == OP_SUB);
                        b_mag_q    <= bus.b[N-2:0];
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    c_q         <= {res_sign_d, res_mag_d};
                    ovf_q       <= res_ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;

endmodule : qadd_seq

// File: tb/tb_qadd_seq.sv
// Directed self-checking bench for qadd_seq.
module tb_qadd_seq;
    import qarith_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    qadd_seq_if #(.N(32)) bus ();

    qadd_seq #(.Q(15), .N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, wait for the result, consume it.
    // lat counts edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                         output logic [31:0] cv, output logic ov, output int lat);
        bus.a        = av;
        bus.b        = bv;
        bus.op       = opv;
        bus.in_valid = 1'b1;
        tick();
        lat          = 1;
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        cv            = bus.c;
        ov            = bus.ovf;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b c=%h ovf=%b exp 0/00000000/0",
                     bus.out_valid, bus.c, bus.ovf);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_add_sub();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vo [4];
        logic [31:0] ec [4];
        logic [31:0] cv;
        logic        ov;
        int          lat;
        va = '{32'h00010000, 32'h00008000, 32'h00000005, 32'h80000005};
        vb = '{32'h00008000, 32'h00010000, 32'h80000003, 32'h00000003};
        vo = '{OP_ADD,       OP_SUB,       OP_ADD,       OP_SUB};
        ec = '{32'h00018000, 32'h80008000, 32'h00000002, 32'h80000008};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vo[i], cv, ov, lat);
            checks++;
            if (cv !== ec[i] || ov !== 1'b0) begin
                failures++;
                $display("FAIL add_sub[%0d] got c=%h ovf=%b exp c=%h ovf=0", i, cv, ov, ec[i]);
            end
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL latency[%0d] got=%0d exp=2", i, lat);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vo [4];
        logic [31:0] cv;
        logic        ov;
        int          lat;
        va = '{32'h80004000, 32'h80000000, 32'h80000000, 32'h00001234};
        vb = '{32'h00004000, 32'h80000000, 32'h00000000, 32'h00001234};
        vo = '{OP_ADD,       OP_ADD,       OP_SUB,       OP_SUB};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vo[i], cv, ov, lat);
            checks++;
            if (cv !== 32'h00000000 || ov !== 1'b0) begin
                failures++;
                $display("FAIL cancel[%0d] got c=%h ovf=%b exp c=00000000 ovf=0", i, cv, ov);
            end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vo [4];
        logic [31:0] ec [4];
        logic        eo [4];
        logic [31:0] cv;
        logic        ov;
        int          lat;
        va = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE, 32'h7FFFFFFF};
        vb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h80000001};
        vo = '{OP_ADD,       OP_SUB,       OP_ADD,       OP_ADD};
        ec = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFE};
        eo = '{1'b1,         1'b1,         1'b0,         1'b0};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vo[i], cv, ov, lat);
            checks++;
            if (cv !== ec[i] || ov !== eo[i]) begin
                failures++;
                $display("FAIL saturate[%0d] got c=%h ovf=%b exp c=%h ovf=%b", i, cv, ov, ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.a        = 32'h00010000;
        bus.b        = 32'h00008000;
        bus.op       = OP_ADD;
        bus.in_valid = 1'b1;
        tick();
        // New operands stay offered through CALC and HOLD; they must wait.
        bus.a  = 32'h00000003;
        bus.b  = 32'h00000001;
        bus.op = OP_SUB;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.c !== 32'h00018000 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d] got valid=%b c=%h ready=%b exp 1/00018000/0",
                         i, bus.out_valid, bus.c, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_accept got ready=%b valid=%b exp 0/0", bus.in_ready, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.c !== 32'h00000002 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL hold_next got valid=%b c=%h ovf=%b exp 1/00000002/0",
                     bus.out_valid, bus.c, bus.ovf);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // out_ready and in_valid held high: one result per three cycles,
    // out_ready during CALC must not cut the result short.
    task automatic test_back_to_back();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vo [3];
        logic [31:0] ec [3];
        va = '{32'h00000005, 32'h80000005, 32'h00000003};
        vb = '{32'h80000003, 32'h00000003, 32'h80000007};
        vo = '{OP_ADD,       OP_SUB,       OP_ADD};
        ec = '{32'h00000002, 32'h80000008, 32'h80000004};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a  = va[i];
            bus.b  = vb[i];
            bus.op = vo[i];
            tick();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_accept[%0d] got ready=%b valid=%b exp 0/0", i, bus.in_ready, bus.out_valid);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.c !== ec[i]) begin
                failures++;
                $display("FAIL b2b_result[%0d] got valid=%b c=%h exp 1/%h", i, bus.out_valid, bus.c, ec[i]);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_release[%0d] got valid=%b ready=%b exp 0/1", i, bus.out_valid, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] cv;
        logic        ov;
        int          lat;
        int          pulses;
        bus.a        = 32'h00010000;
        bus.b        = 32'h00008000;
        bus.op       = OP_ADD;
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_state got valid=%b c=%h ovf=%b ready=%b exp 0/00000000/0/1",
                     bus.out_valid, bus.c, bus.ovf, bus.in_ready);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_no_pulse got pulses=%0d ready=%b exp 0/1", pulses, bus.in_ready);
        end
        do_op(32'h00000010, 32'h00000001, OP_SUB, cv, ov, lat);
        checks++;
        if (cv !== 32'h0000000F || ov !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL abort_recover got c=%h ovf=%b lat=%0d exp 0000000F/0/2", cv, ov, lat);
        end
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        checks        = 0;
        failures      = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        bus.out_ready = 1'b0;

        test_reset();
        test_add_sub();
        test_cancel();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_qadd_seq

// File: doc/qadd_seq.md
QADD_SEQ -- requirements
Module: qadd_seq

Interface
REQ-001 The module SHALL have parameter Q, default 15, meaning the number of fractional bits in the sign-magnitude Q format.
REQ-002 The module SHALL have parameter N, default 32, meaning the total word width; bit N-1 is the sign and bits N-2:0 are the magnitude.
REQ-003 Port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-004 Port rst  input  1  meaning a synchronous, active-high reset.
REQ-005 Port in_valid  input  1  meaning operands a, b and op are presented.
REQ-006 Port in_ready  output  1  meaning the block can accept an operand pair.
REQ-007 Port a  input  N  meaning the first sign-magnitude operand.
REQ-008 Port b  input  N  meaning the second sign-magnitude operand.
REQ-009 Port op  input  1  meaning the operation: 0 computes a+b, 1 computes a-b.
REQ-010 Port out_valid  output  1  meaning c and ovf hold a valid result.
REQ-011 Port out_ready  input  1  meaning the downstream consumer accepts the result.
REQ-012 Port c  output  N  meaning the sign-magnitude result.
REQ-013 Port ovf  output  1  meaning the magnitude saturated on this result.

Function
REQ-014 The block SHALL use an FSM with three states, IDLE, CALC and HOLD, and SHALL set in_ready=1 only in IDLE.
REQ-015 In IDLE, when in_valid=1, the block SHALL register a, b and op, and SHALL set the effective sign of b to b[N-1] XOR op.
REQ-016 On that same accepting edge, the FSM SHALL move from IDLE to CALC.
REQ-017 In CALC, the block SHALL compute the result, register it into c and ovf, set out_valid=1, and move to HOLD.
REQ-018 Latency SHALL be fixed: out_valid rises exactly 2 clk edges after the accepting edge.
REQ-019 In HOLD, c, ovf and out_valid SHALL stay stable until out_ready=1 is sampled.
REQ-020 When out_ready=1 is sampled in HOLD, the block SHALL clear out_valid and return to IDLE.
REQ-021 There SHALL be no same-cycle bypass, so throughput is at most one result every 3 cycles.
REQ-022 An out_ready pulse outside HOLD SHALL be ignored.
REQ-023 An in_valid pulse outside IDLE SHALL be ignored and SHALL NOT be captured.
REQ-024 When the effective signs are equal, magnitude SHALL be a_mag+b_mag computed N bits wide, and the sign SHALL be the common sign.
REQ-025 If the sum carries into bit N-1, the magnitude SHALL saturate to all ones (2^(N-1)-1) and ovf SHALL be set to 1.
REQ-026 When the effective signs differ, magnitude SHALL be the larger magnitude minus the smaller, the sign SHALL be that of the larger, and ovf SHALL be 0.
REQ-027 When the magnitudes are equal and the signs differ, the result SHALL be exactly 0 with sign 0.
REQ-028 Negative-zero inputs (sign 1, magnitude 0) SHALL be treated as +0.
REQ-029 c SHALL never be emitted as negative zero: any zero magnitude SHALL force the sign to 0.
REQ-030 The result SHALL be independent of Q; Q only documents the format, since alignment is identical for both operands.

Reset
REQ-031 While rst=1 at a clk edge, the FSM SHALL enter IDLE.
REQ-032 Reset SHALL drive out_valid=0, c=0, ovf=0 and clear all operand registers; in_ready SHALL be 1 in the first cycle after reset.
REQ-033 Reset asserted in CALC or HOLD SHALL abort the operation, drop the pending result with no out_valid pulse, and accept no operand on that edge.

Structure
REQ-034 Package qarith_pkg SHALL hold the default Q and N values.
REQ-035 qarith_pkg SHALL hold the state enum {IDLE, CALC, HOLD}.
REQ-036 qarith_pkg SHALL hold the op encoding constants OP_ADD=0 and OP_SUB=1.
REQ-037 qarith_pkg SHALL hold the sign-magnitude sign-bit index constant.
REQ-038 One combinational sub-module, qmag_addsub, SHALL take (sign_a, mag_a, sign_b, mag_b) and return (sign, mag, ovf); it is instantiated in the CALC datapath.

Verification
REQ-039 Bench scenario: a=0x00010000 (+2.0), b=0x00008000 (+1.0), op=0 -> c=0x00018000, ovf=0, out_valid exactly 2 edges after acceptance.
REQ-040 Bench scenario: a=0x00008000, b=0x00010000, op=1 -> c=0x80008000 (-1.0), ovf=0.
REQ-041 Bench scenario: a=0x80004000, b=0x00004000, op=0 -> c=0x00000000; also a=0x80000000, b=0x80000000 -> c=0x00000000.
REQ-042 Bench scenario: a=0x7FFFFFFF, b=0x00000001, op=0 -> c=0x7FFFFFFF, ovf=1; a=0xFFFFFFFF, b=0x00000001, op=1 -> c=0xFFFFFFFF, ovf=1.
REQ-043 Bench scenario: hold out_ready=0 for 5 cycles while in_valid stays 1 with new operands -> c stays stable, in_ready=0, and the new operands are accepted only in the cycle after the out_ready handshake.
REQ-044 Bench scenario: assert rst in the cycle after acceptance (CALC) -> no out_valid pulse, c=0, and in_ready=1 on the next cycle.
